// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way set-associative cache controller.
// Address layout: tag=[19:6], index=[5:2], byte offset [1:0] ignored.
package cache_pkg;

    localparam int TAG_W  = 14;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 20;
    localparam int NSETS  = 1 << IDX_W;

    localparam int IDX_LSB = 2;
    localparam int IDX_MSB = IDX_LSB + IDX_W - 1;
    localparam int TAG_LSB = IDX_MSB + 1;
    localparam int TAG_MSB = TAG_LSB + TAG_W - 1;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        RESPOND
    } state_t;

    function automatic addr_t line_addr(input tag_t tag, input idx_t idx);
        return {tag, idx, 2'b00};
    endfunction

endpackage

// File: rtl/cache_if.sv
// CPU load/store port and main-memory handshake bundles.
// The controller is the slave of the CPU port and the master of the memory port.
interface cache_cpu_if;
    import cache_pkg::*;

    logic  req_valid;
    logic  req_wr;
    addr_t req_addr;
    word_t req_wdata;
    logic  req_ready;
    logic  resp_valid;
    word_t resp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

interface cache_mem_if;
    import cache_pkg::*;

    logic  mem_req;
    logic  mem_wr;
    addr_t mem_addr;
    word_t mem_wdata;
    word_t mem_rdata;
    logic  mem_ack;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cache_victim_sel.sv
// Replacement choice on a miss: first invalid way, else the way with ref=0,
// else way0 when both refs agree. victim=0 selects way0.
module cache_victim_sel (
    input  logic w0_valid,
    input  logic w1_valid,
    input  logic w0_ref,
    input  logic w1_ref,
    output logic victim
);

    always_comb begin
        victim = 1'b0;
        if (w0_valid) begin
            if (!w1_valid)
                victim = 1'b1;
            else if (w0_ref && !w1_ref)
                victim = 1'b1;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate controller for a 2-way, 16-set, one-word-line cache.
// Tag/flag stores live outside; the data array is held here.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    cache_cpu_if.slave       cpu,
    cache_mem_if.master      mem,
    output idx_t             tag_index,
    output logic             w0_ref_wen,
    output logic             w1_ref_wen,
    output logic             w0_flg_wen,
    output logic             w1_flg_wen,
    output logic             w0_valid_in,
    output logic             w0_dirty_in,
    output logic             w0_ref_in,
    output logic             w1_valid_in,
    output logic             w1_dirty_in,
    output logic             w1_ref_in,
    output tag_t             tag_in,
    input  logic             w0_valid,
    input  logic             w0_dirty,
    input  logic             w0_ref,
    input  logic             w1_valid,
    input  logic             w1_dirty,
    input  logic             w1_ref,
    input  tag_t             w0_tag,
    input  tag_t             w1_tag
);

    state_t               state, state_nxt;
    logic                 r_wr;
    logic [ADDR_W-1:2]    r_addr;
    word_t                r_wdata;
    logic                 r_way;

    word_t                data0 [NSETS];
    word_t                data1 [NSETS];

    logic                 line_wen;
    logic                 line_way;
    word_t                line_wdata;

    tag_t                 req_tag;
    idx_t                 idx;
    logic                 hit0, hit1, hit, hit_way;
    logic                 vsel, miss_dirty;
    word_t                line_data;
    tag_t                 victim_tag;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^cpu.req_addr[1:0];

    assign req_tag   = r_addr[TAG_MSB:TAG_LSB];
    assign idx       = r_addr[IDX_MSB:IDX_LSB];
    assign tag_index = idx;

    // Both ways matching means corrupted tags; way0 takes priority.
    assign hit0    = w0_valid && (w0_tag == req_tag);
    assign hit1    = w1_valid && (w1_tag == req_tag) && !hit0;
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;

    cache_victim_sel u_victim_sel (
        .w0_valid (w0_valid),
        .w1_valid (w1_valid),
        .w0_ref   (w0_ref),
        .w1_ref   (w1_ref),
        .victim   (vsel)
    );

    assign miss_dirty = vsel ? (w1_valid && w1_dirty) : (w0_valid && w0_dirty);
    assign line_data  = r_way ? data1[idx] : data0[idx];
    assign victim_tag = r_way ? w1_tag : w0_tag;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_way   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cpu.req_valid) begin
                r_wr    <= cpu.req_wr;
                r_addr  <= cpu.req_addr[ADDR_W-1:2];
                r_wdata <= cpu.req_wdata;
            end
            if (state == LOOKUP)
                r_way <= hit ? hit_way : vsel;
        end
    end

    // NOTE: the data array has no reset; invalid tag-store entries mask stale contents.
    always_ff @(posedge clk) begin
        if (line_wen) begin
            if (line_way)
                data1[idx] <= line_wdata;
            else
                data0[idx] <= line_wdata;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt      = state;
        cpu.req_ready  = 1'b0;
        cpu.resp_valid = 1'b0;
        cpu.resp_rdata = '0;
        mem.mem_req    = 1'b0;
        mem.mem_wr     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        w0_ref_wen     = 1'b0;
        w1_ref_wen     = 1'b0;
        w0_flg_wen     = 1'b0;
        w1_flg_wen     = 1'b0;
        w0_valid_in    = 1'b0;
        w0_dirty_in    = 1'b0;
        w0_ref_in      = 1'b0;
        w1_valid_in    = 1'b0;
        w1_dirty_in    = 1'b0;
        w1_ref_in      = 1'b0;
        tag_in         = '0;
        line_wen       = 1'b0;
        line_way       = 1'b0;
        line_wdata     = '0;

        case (state)
            IDLE: begin
                cpu.req_ready = 1'b1;
                if (cpu.req_valid)
                    state_nxt = LOOKUP;
            end

            LOOKUP: begin
                if (hit) begin
                    w0_ref_wen = 1'b1;
                    w1_ref_wen = 1'b1;
                    w0_ref_in  = !hit_way;
                    w1_ref_in  = hit_way;
                    if (r_wr) begin
                        w0_flg_wen  = !hit_way;
                        w1_flg_wen  = hit_way;
                        w0_valid_in = 1'b1;
                        w1_valid_in = 1'b1;
                        w0_dirty_in = 1'b1;
                        w1_dirty_in = 1'b1;
                        tag_in      = req_tag;
                        line_wen    = 1'b1;
                        line_way    = hit_way;
                        line_wdata  = r_wdata;
                    end
                    state_nxt = RESPOND;
                end else begin
                    state_nxt = miss_dirty ? WRITEBACK : REFILL;
                end
            end

            WRITEBACK: begin
                mem.mem_req   = 1'b1;
                mem.mem_wr    = 1'b1;
                mem.mem_addr  = line_addr(victim_tag, idx);
                mem.mem_wdata = line_data;
                if (mem.mem_ack)
                    state_nxt = REFILL;
            end

            REFILL: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = line_addr(req_tag, idx);
                if (mem.mem_ack) begin
                    line_wen    = 1'b1;
                    line_way    = r_way;
                    line_wdata  = r_wr ? r_wdata : mem.mem_rdata;
                    w0_flg_wen  = !r_way;
                    w1_flg_wen  = r_way;
                    w0_valid_in = 1'b1;
                    w1_valid_in = 1'b1;
                    w0_dirty_in = r_wr;
                    w1_dirty_in = r_wr;
                    tag_in      = req_tag;
                    w0_ref_wen  = 1'b1;
                    w1_ref_wen  = 1'b1;
                    w0_ref_in   = !r_way;
                    w1_ref_in   = r_way;
                    state_nxt   = RESPOND;
                end
            end

            RESPOND: begin
                cpu.resp_valid = 1'b1;
                cpu.resp_rdata = r_wr ? '0 : line_data;
                state_nxt      = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: tag-store and memory models plus a
// response/memory-transaction scoreboard filled as stimulus is driven.
module tb_cache_ctrl;
    import cache_pkg::*;

    typedef struct {
        bit    wr;
        addr_t addr;
        word_t data;
    } mem_txn_t;

    logic clk;
    logic rst;

    cache_cpu_if cpu ();
    cache_mem_if mem ();

    idx_t tag_index;
    logic w0_ref_wen, w1_ref_wen, w0_flg_wen, w1_flg_wen;
    logic w0_valid_in, w0_dirty_in, w0_ref_in, w1_valid_in, w1_dirty_in, w1_ref_in;
    tag_t tag_in;
    logic w0_valid, w0_dirty, w0_ref, w1_valid, w1_dirty, w1_ref;
    tag_t w0_tag, w1_tag;

    cache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (cpu),
        .mem         (mem),
        .tag_index   (tag_index),
        .w0_ref_wen  (w0_ref_wen),
        .w1_ref_wen  (w1_ref_wen),
        .w0_flg_wen  (w0_flg_wen),
        .w1_flg_wen  (w1_flg_wen),
        .w0_valid_in (w0_valid_in),
        .w0_dirty_in (w0_dirty_in),
        .w0_ref_in   (w0_ref_in),
        .w1_valid_in (w1_valid_in),
        .w1_dirty_in (w1_dirty_in),
        .w1_ref_in   (w1_ref_in),
        .tag_in      (tag_in),
        .w0_valid    (w0_valid),
        .w0_dirty    (w0_dirty),
        .w0_ref      (w0_ref),
        .w1_valid    (w1_valid),
        .w1_dirty    (w1_dirty),
        .w1_ref      (w1_ref),
        .w0_tag      (w0_tag),
        .w1_tag      (w1_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two CachePart tag/flag stores: combinational read, synchronous write.
    logic v0 [NSETS], d0 [NSETS], r0 [NSETS];
    logic v1 [NSETS], d1 [NSETS], r1 [NSETS];
    tag_t t0 [NSETS], t1 [NSETS];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSETS; i++) begin
                v0[i] <= 1'b0; d0[i] <= 1'b0; r0[i] <= 1'b0; t0[i] <= '0;
                v1[i] <= 1'b0; d1[i] <= 1'b0; r1[i] <= 1'b0; t1[i] <= '0;
            end
        end else begin
            if (w0_ref_wen) r0[tag_index] <= w0_ref_in;
            if (w1_ref_wen) r1[tag_index] <= w1_ref_in;
            if (w0_flg_wen) begin
                v0[tag_index] <= w0_valid_in;
                d0[tag_index] <= w0_dirty_in;
                t0[tag_index] <= tag_in;
            end
            if (w1_flg_wen) begin
                v1[tag_index] <= w1_valid_in;
                d1[tag_index] <= w1_dirty_in;
                t1[tag_index] <= tag_in;
            end
        end
    end

    assign w0_valid = v0[tag_index];
    assign w0_dirty = d0[tag_index];
    assign w0_ref   = r0[tag_index];
    assign w0_tag   = t0[tag_index];
    assign w1_valid = v1[tag_index];
    assign w1_dirty = d1[tag_index];
    assign w1_ref   = r1[tag_index];
    assign w1_tag   = t1[tag_index];

    int       n_checks = 0;
    int       n_pass   = 0;
    word_t    resp_q [$];
    mem_txn_t mem_q  [$];
    word_t    mem_model [addr_t];
    int       mem_lat  = 2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory: acks mem_lat cycles after the first cycle mem_req is seen high.
    initial begin : memory
        int    cnt;
        mem_txn_t e;
        cnt           = 0;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem.mem_ack || !mem.mem_req)
                cnt = 0;
            mem.mem_ack = 1'b0;
            if (mem.mem_req) begin
                cnt++;
                if (cnt == mem_lat + 1) begin
                    if (mem_q.size() == 0) begin
                        check("mem_unexp", {31'd0, mem.mem_req}, 32'd0);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_wr", {31'd0, mem.mem_wr}, {31'd0, e.wr});
                        check("mem_addr", {12'd0, mem.mem_addr}, {12'd0, e.addr});
                        if (e.wr) begin
                            check("mem_wdata", mem.mem_wdata, e.data);
                            mem_model[mem.mem_addr] = mem.mem_wdata;
                        end else begin
                            mem.mem_rdata = mem_model.exists(mem.mem_addr) ?
                                            mem_model[mem.mem_addr] : 32'h0;
                        end
                    end
                    mem.mem_ack = 1'b1;
                end
            end
        end
    end

    // Response monitor: every resp_valid pulse consumes one expected word.
    initial begin : resp_monitor
        forever begin
            @(negedge clk);
            if (cpu.resp_valid) begin
                if (resp_q.size() == 0)
                    check("resp_unexp", {31'd0, cpu.resp_valid}, 32'd0);
                else
                    check("resp_rdata", cpu.resp_rdata, resp_q.pop_front());
            end
        end
    end

    task automatic do_req(input bit wr, input addr_t addr, input word_t wdata,
                          input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, {31'd0, cpu.req_ready}, 32'd1);
        cpu.req_valid = 1'b1;
        cpu.req_wr    = wr;
        cpu.req_addr  = addr;
        cpu.req_wdata = wdata;
        @(negedge clk);
        cpu.req_valid = 1'b0;
        lat = 1;
        while (!cpu.resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_mreq_low"}, {31'd0, mem.mem_req}, 32'd0);
        @(negedge clk);
    endtask

    initial begin : main
        int n_resp, first_at, second_at, busy_ready;

        cpu.req_valid = 1'b0;
        cpu.req_wr    = 1'b0;
        cpu.req_addr  = '0;
        cpu.req_wdata = '0;
        mem_model[20'h00044] = 32'hDEADBEEF;
        mem_model[20'h00084] = 32'h55555555;
        mem_model[20'h000C4] = 32'h0C0C0C0C;
        mem_model[20'h00104] = 32'h01040104;
        mem_model[20'h00144] = 32'h01440144;
        mem_model[20'h00200] = 32'hCAFE0200;

        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, cpu.req_ready}, 32'd1);
        check("rst_mreq", {31'd0, mem.mem_req}, 32'd0);
        check("rst_resp", {31'd0, cpu.resp_valid}, 32'd0);
        check("rst_index", {28'd0, tag_index}, 32'd0);
        rst = 1'b1;

        // Reset while a refill is outstanding: the request is dropped silently.
        mem_lat = 50;
        @(negedge clk);
        cpu.req_valid = 1'b1;
        cpu.req_wr    = 1'b0;
        cpu.req_addr  = 20'h00200;
        @(negedge clk);
        cpu.req_valid = 1'b0;
        for (int i = 0; i < 10 && !mem.mem_req; i++) @(negedge clk);
        check("refill_mreq_up", {31'd0, mem.mem_req}, 32'd1);
        check("refill_ready_low", {31'd0, cpu.req_ready}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_mreq_drop", {31'd0, mem.mem_req}, 32'd0);
        check("async_ready", {31'd0, cpu.req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_lat = 2;

        mem_q.push_back('{1'b0, 20'h00200, 32'h0});
        resp_q.push_back(32'hCAFE0200);
        do_req(1'b0, 20'h00200, '0, 5, "post_rst_miss");

        mem_q.push_back('{1'b0, 20'h00044, 32'h0});
        resp_q.push_back(32'hDEADBEEF);
        do_req(1'b0, 20'h00044, '0, 5, "cold");
        check("cold_v0", {31'd0, v0[1]}, 32'd1);
        check("cold_d0", {31'd0, d0[1]}, 32'd0);
        check("cold_r0", {31'd0, r0[1]}, 32'd1);
        check("cold_t0", {18'd0, t0[1]}, 32'd1);

        resp_q.push_back(32'hDEADBEEF);
        do_req(1'b0, 20'h00044, '0, 2, "rehit");

        mem_q.push_back('{1'b0, 20'h00084, 32'h0});
        resp_q.push_back(32'h0);
        do_req(1'b1, 20'h00084, 32'h12345678, 5, "st_miss");
        check("st_r0", {31'd0, r0[1]}, 32'd0);
        check("st_r1", {31'd0, r1[1]}, 32'd1);
        check("st_v1", {31'd0, v1[1]}, 32'd1);
        check("st_d1", {31'd0, d1[1]}, 32'd1);
        check("st_t1", {18'd0, t1[1]}, 32'd2);

        resp_q.push_back(32'h12345678);
        do_req(1'b0, 20'h00084, '0, 2, "st_readback");

        mem_q.push_back('{1'b0, 20'h000C4, 32'h0});
        resp_q.push_back(32'h0C0C0C0C);
        do_req(1'b0, 20'h000C4, '0, 5, "clean_evict");
        check("ce_t0", {18'd0, t0[1]}, 32'd3);
        check("ce_d0", {31'd0, d0[1]}, 32'd0);
        check("ce_r0", {31'd0, r0[1]}, 32'd1);
        check("ce_r1", {31'd0, r1[1]}, 32'd0);
        check("ce_t1_kept", {18'd0, t1[1]}, 32'd2);

        mem_q.push_back('{1'b1, 20'h00084, 32'h12345678});
        mem_q.push_back('{1'b0, 20'h00104, 32'h0});
        resp_q.push_back(32'h01040104);
        do_req(1'b0, 20'h00104, '0, 8, "dirty_evict");
        check("de_t1", {18'd0, t1[1]}, 32'd4);
        check("de_d1", {31'd0, d1[1]}, 32'd0);
        check("de_mem84", mem_model[20'h00084], 32'h12345678);

        // req_valid held through a miss: one response, then a second acceptance from IDLE.
        mem_q.push_back('{1'b0, 20'h00144, 32'h0});
        resp_q.push_back(32'h01440144);
        resp_q.push_back(32'h01440144);
        n_resp = 0; first_at = 0; second_at = 0; busy_ready = 0;
        @(negedge clk);
        cpu.req_valid = 1'b1;
        cpu.req_wr    = 1'b0;
        cpu.req_addr  = 20'h00144;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cpu.resp_valid) begin
                n_resp++;
                if (n_resp == 1) first_at = cyc;
                if (n_resp == 2) second_at = cyc;
            end
            if (cyc <= 5 && cpu.req_ready) busy_ready++;
            if (cyc == 7) cpu.req_valid = 1'b0;
        end
        check("hold_nresp", n_resp, 2);
        check("hold_first", first_at, 5);
        check("hold_second", second_at, 8);
        check("hold_busy_ready", busy_ready, 0);

        resp_q.push_back(32'h0);
        do_req(1'b1, 20'h00144, 32'hA5A5A5A5, 2, "st_hit");
        check("sh_d0", {31'd0, d0[1]}, 32'd1);
        resp_q.push_back(32'hA5A5A5A5);
        do_req(1'b0, 20'h00144, '0, 2, "sh_readback");

        repeat (3) @(negedge clk);
        check("resp_q_empty", resp_q.size(), 0);
        check("mem_q_empty", mem_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- 2-way set-associative, write-back, write-allocate cache controller.
- Drives two CachePart tag/flag stores (way0, way1): valid, dirty, ref and a 14-bit tag per set, 16 sets.
- Holds the 2x16x32 data array internally.
- Sits between the CPU load/store port and the main-memory handshake.

Parameters:
- TAG_W, 14, tag width; equals CachePart tag width.
- IDX_W, 4, set index width; 16 sets.
- DATA_W, 32, word width; one word per line.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; also drives both CachePart instances.
- req_valid  in  1  CPU request present.
- req_wr  in  1  1=store, 0=load.
- req_addr  in  20  byte address: tag=[19:6], index=[5:2]; [1:0] ignored.
- req_wdata  in  32  store data.
- req_ready  out  1  controller accepts a request this cycle.
- resp_valid  out  1  one-cycle pulse; load data / store completion.
- resp_rdata  out  32  load data, valid with resp_valid; 0 for stores.
- mem_req  out  1  memory request, held until mem_ack.
- mem_wr  out  1  1=writeback, 0=refill read.
- mem_addr  out  20  word-aligned address, [1:0]=0.
- mem_wdata  out  32  writeback data.
- mem_rdata  in  32  refill data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- tag_index  out  4  index to both ways.
- w0_ref_wen, w1_ref_wen  out  1 each  ref-bit write enables.
- w0_flg_wen, w1_flg_wen  out  1 each  valid/dirty/tag write enables.
- w0_valid_in/w0_dirty_in/w0_ref_in, w1_* (same)  out  1 each  write data.
- tag_in  out  14  tag write data, shared by both ways.
- w0_valid/w0_dirty/w0_ref, w1_* (same)  in  1 each  read data.
- w0_tag, w1_tag  in  14 each  read tags.

Behaviour:
- Tag stores: combinational read from tag_index; synchronous write.
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs 0, except req_ready=1.
  - Data array is not cleared; valid=0 in the tag stores masks it.
  - Reset mid-operation drops mem_req immediately. Any in-flight request is lost and produces no response.
- FSM states and transitions:
  - IDLE:
    - req_ready=1.
    - On req_valid, latch req_wr, req_addr and req_wdata, then go to LOOKUP.
    - tag_index follows the latched address from LOOKUP onward.
  - LOOKUP:
    - hitN = wN_valid & (wN_tag==tag). Both ways hitting is a corruption case; way0 wins.
    - Hit:
      - Update ref: hit way ref=1, other way ref=0 (both ref_wen asserted).
      - Store hit: write data word, flg_wen on the hit way with valid=1, dirty=1, same tag.
      - Go to RESPOND.
    - Miss, victim selection:
      - If any way is invalid, pick the first invalid way (way0 preferred).
      - Otherwise pick the way with ref=0; if both refs are equal, pick way0.
      - Register the victim.
    - Miss, next state: victim valid & dirty -> WRITEBACK; otherwise -> REFILL.
  - WRITEBACK:
    - mem_req=1, mem_wr=1.
    - mem_addr={victim tag, index, 2'b00}; mem_wdata=victim data.
    - On mem_ack, go to REFILL.
  - REFILL:
    - mem_req=1, mem_wr=0, mem_addr={req tag, index, 2'b00}.
    - On mem_ack:
      - Write mem_rdata into the victim line; for a store, req_wdata overrides it.
      - flg_wen on the victim with valid=1, dirty=req_wr, tag_in=req tag.
      - ref update as for a hit.
      - Go to RESPOND.
  - RESPOND:
    - resp_valid=1 for one cycle.
    - resp_rdata = line data (loads only).
    - Return to IDLE.
- mem_req drops in the cycle after mem_ack. The memory must not pulse mem_ack unless mem_req is high.
- Latency from acceptance to resp_valid:
  - hit: 2 cycles.
  - clean miss: 3 + memory latency.
  - dirty miss: 4 + two memory latencies.
- req_ready=0 outside IDLE; req_valid is ignored then.
- One outstanding request; no forwarding needed.

Decomposition:
- Shared package cache_pkg holds:
  - TAG_W, IDX_W, DATA_W.
  - Address field slice constants.
  - FSM state encoding: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- Natural sub-module: cache_victim_sel, combinational.
  - Inputs: valid and ref of both ways.
  - Output: victim way.
- cache_ctrl instantiates no CachePart; the top-level cache wires them up.

Test Plan:
- Reset with rst=0 mid-REFILL (mem_req=1): mem_req->0 asynchronously, req_ready=1; after release, a load to the same address misses again.
- Cold load 0x00044 (tag 1, idx 1): mem_req with mem_addr=0x00044, mem_wr=0; mem_ack with 0xDEADBEEF -> resp_rdata=0xDEADBEEF; way0 valid=1, dirty=0, ref=1.
- Repeat load 0x00044: no mem_req; resp_valid exactly 2 cycles after acceptance, data 0xDEADBEEF.
- Store 0x12345678 to 0x00084 (idx 1, tag 2):
  - Allocates way1; way0 ref=0, way1 ref=1, way1 dirty=1.
  - A following load of 0x00084 hits with 0x12345678.
- Load 0x000C4 (idx 1, tag 3), both ways valid, way0 ref=0:
  - way0 is clean, so the victim needs no writeback: a single read at 0x000C4.
  - Then a load of 0x00104 evicts dirty way1: writeback mem_wr=1, mem_addr=0x00084, mem_wdata=0x12345678, then a refill read at 0x00104.
- req_valid held high during a miss: exactly one response; the second request is accepted only after returning to IDLE.
